// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dmem arbiter: owner encoding and default bus widths.
package dmem_arbiter_pkg;

   localparam int DMEM_ADDR_W = 12;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic {
      OWNER_P = 1'b0,
      OWNER_S = 1'b1
   } owner_e;

endpackage

// File: rtl/dmem_arbiter_arb2_pick.sv
// Two-way grant decision for the dmem arbiter: round-robin, or P-priority with an
// S starvation counter that forces one S grant after STARVE_MAX blocked cycles.
module arb2_pick
   import dmem_arbiter_pkg::*;
#(
   parameter int P_PRIORITY = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic p_req,
   input  logic s_req,
   output logic p_gnt,
   output logic s_gnt
);

   generate
      if (P_PRIORITY == 0) begin : g_rr
         owner_e r_last_owner;
         logic   w_p_wins;

         // On contention the port that did not own the previous grant wins.
         assign w_p_wins = (r_last_owner == OWNER_S);
         assign p_gnt    = ~reset & p_req & (~s_req | w_p_wins);
         assign s_gnt    = ~reset & s_req & (~p_req | ~w_p_wins);

         always_ff @(posedge clock) begin
            if (reset) begin
               r_last_owner <= OWNER_S;
            end else if (p_gnt) begin
               r_last_owner <= OWNER_P;
            end else if (s_gnt) begin
               r_last_owner <= OWNER_S;
            end
         end
      end else begin : g_fp
         localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
         localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

         logic [CW-1:0] r_starve_cnt;
         logic          w_force;

         assign w_force = (STARVE_MAX != 0) && (r_starve_cnt == CNT_MAX);
         assign s_gnt   = ~reset & s_req & (w_force | ~p_req);
         assign p_gnt   = ~reset & p_req & ~s_gnt;

         // Counts cycles S waited behind P; saturates so the force stays armed.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_starve_cnt <= '0;
            end else if (s_gnt || !s_req) begin
               r_starve_cnt <= '0;
            end else if (p_gnt && (r_starve_cnt != CNT_MAX)) begin
               r_starve_cnt <= r_starve_cnt + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous dmem between the processor (P) and a secondary
// master (S); routes read data back to the issuing port one cycle after its grant.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DMEM_ADDR_W,
   parameter int DATA_W     = DMEM_DATA_W,
   parameter int P_PRIORITY = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_gnt,
   output logic              p_stall,
   output logic              p_rvalid,
   output logic [DATA_W-1:0] p_rdata,
   input  logic              s_req,
   input  logic              s_we,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_wdata,
   output logic              s_gnt,
   output logic              s_rvalid,
   output logic [DATA_W-1:0] s_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   logic              w_p_gnt;
   logic              w_s_gnt;
   logic              w_rd_gnt;
   logic [ADDR_W-1:0] r_addr_hold;
   logic [DATA_W-1:0] r_data_hold;
   logic              r_pend;
   owner_e            r_tag;

   arb2_pick #(
      .P_PRIORITY (P_PRIORITY),
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clock (clock),
      .reset (reset),
      .p_req (p_req),
      .s_req (s_req),
      .p_gnt (w_p_gnt),
      .s_gnt (w_s_gnt)
   );

   assign p_gnt   = w_p_gnt;
   assign s_gnt   = w_s_gnt;
   assign p_stall = p_req & ~w_p_gnt;

   // Idle cycles replay the last address/data so the dmem never sees a stray address.
   always_comb begin
      mem_addr = r_addr_hold;
      mem_data = r_data_hold;
      mem_wren = 1'b0;
      if (reset) begin
         mem_addr = '0;
         mem_data = '0;
      end else if (w_p_gnt) begin
         mem_addr = p_addr;
         mem_data = p_wdata;
         mem_wren = p_we;
      end else if (w_s_gnt) begin
         mem_addr = s_addr;
         mem_data = s_wdata;
         mem_wren = s_we;
      end
   end

   assign w_rd_gnt = (w_p_gnt & ~p_we) | (w_s_gnt & ~s_we);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr_hold <= '0;
         r_data_hold <= '0;
         r_pend      <= 1'b0;
         r_tag       <= OWNER_P;
      end else begin
         r_addr_hold <= mem_addr;
         r_data_hold <= mem_data;
         r_pend      <= w_rd_gnt;
         r_tag       <= w_s_gnt ? OWNER_S : OWNER_P;
      end
   end

   assign p_rvalid = r_pend & (r_tag == OWNER_P);
   assign s_rvalid = r_pend & (r_tag == OWNER_S);
   assign p_rdata  = mem_q;
   assign s_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (a) and a fixed-priority instance (b),
// each with its own dmem model and a read-return scoreboard.
module tb_dmem_arbiter;

   typedef struct {
      bit          own;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   logic        p_req_a = 0, p_we_a = 0, s_req_a = 0, s_we_a = 0;
   logic [11:0] p_addr_a = 0, s_addr_a = 0;
   logic [31:0] p_wdata_a = 0, s_wdata_a = 0;
   logic        p_gnt_a, p_stall_a, p_rvalid_a, s_gnt_a, s_rvalid_a, mem_wren_a;
   logic [31:0] p_rdata_a, s_rdata_a, mem_data_a, mem_q_a;
   logic [11:0] mem_addr_a;

   logic        p_req_b = 0, p_we_b = 0, s_req_b = 0, s_we_b = 0;
   logic [11:0] p_addr_b = 0, s_addr_b = 0;
   logic [31:0] p_wdata_b = 0, s_wdata_b = 0;
   logic        p_gnt_b, p_stall_b, p_rvalid_b, s_gnt_b, s_rvalid_b, mem_wren_b;
   logic [31:0] p_rdata_b, s_rdata_b, mem_data_b, mem_q_b;
   logic [11:0] mem_addr_b;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .P_PRIORITY(0), .STARVE_MAX(4)) u_rr (
      .clock(clock), .reset(reset),
      .p_req(p_req_a), .p_we(p_we_a), .p_addr(p_addr_a), .p_wdata(p_wdata_a),
      .p_gnt(p_gnt_a), .p_stall(p_stall_a), .p_rvalid(p_rvalid_a), .p_rdata(p_rdata_a),
      .s_req(s_req_a), .s_we(s_we_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a),
      .s_gnt(s_gnt_a), .s_rvalid(s_rvalid_a), .s_rdata(s_rdata_a),
      .mem_addr(mem_addr_a), .mem_data(mem_data_a), .mem_wren(mem_wren_a), .mem_q(mem_q_a)
   );

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .P_PRIORITY(1), .STARVE_MAX(4)) u_fp (
      .clock(clock), .reset(reset),
      .p_req(p_req_b), .p_we(p_we_b), .p_addr(p_addr_b), .p_wdata(p_wdata_b),
      .p_gnt(p_gnt_b), .p_stall(p_stall_b), .p_rvalid(p_rvalid_b), .p_rdata(p_rdata_b),
      .s_req(s_req_b), .s_we(s_we_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b),
      .s_gnt(s_gnt_b), .s_rvalid(s_rvalid_b), .s_rdata(s_rdata_b),
      .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b), .mem_q(mem_q_b)
   );

   function automatic logic [31:0] pat(logic [11:0] a);
      return 32'hC0DE0000 | {20'h0, a};
   endfunction

   // dmem models: unwritten words read back as a known address pattern
   bit [31:0] mem_a [4096];
   bit        wr_a  [4096];
   bit [31:0] mem_b [4096];
   bit        wr_b  [4096];

   always @(posedge clock) begin
      if (mem_wren_a) begin
         mem_a[mem_addr_a] <= mem_data_a;
         wr_a[mem_addr_a]  <= 1'b1;
      end
      mem_q_a <= wr_a[mem_addr_a] ? mem_a[mem_addr_a] : pat(mem_addr_a);
      if (mem_wren_b) begin
         mem_b[mem_addr_b] <= mem_data_b;
         wr_b[mem_addr_b]  <= 1'b1;
      end
      mem_q_b <= wr_b[mem_addr_b] ? mem_b[mem_addr_b] : pat(mem_addr_b);
   end

   // read-return scoreboards
   always @(negedge clock) begin : mon_a
      exp_t        e;
      logic [31:0] got;
      while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
         n_vec++; n_err++;
         $display("FAIL rv_missing_a: no rvalid at cycle %0d, want owner %0d data %h", q_a[0].cyc, q_a[0].own, q_a[0].data);
         void'(q_a.pop_front());
      end
      if (p_rvalid_a || s_rvalid_a) begin
         n_vec++;
         got = p_rvalid_a ? p_rdata_a : s_rdata_a;
         if (p_rvalid_a && s_rvalid_a) begin
            n_err++; $display("FAIL rv_both_a: both rvalid high at cycle %0d", cyc);
         end else if (q_a.size() == 0 || q_a[0].cyc != cyc) begin
            n_err++; $display("FAIL rv_unexpected_a: rvalid p=%b s=%b at cycle %0d, want none", p_rvalid_a, s_rvalid_a, cyc);
         end else begin
            e = q_a.pop_front();
            if (s_rvalid_a !== e.own || got !== e.data) begin
               n_err++;
               $display("FAIL rv_data_a: cycle %0d got owner %0d data %h, want owner %0d data %h", cyc, s_rvalid_a, got, e.own, e.data);
            end
         end
      end
   end

   always @(negedge clock) begin : mon_b
      exp_t        e;
      logic [31:0] got;
      while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
         n_vec++; n_err++;
         $display("FAIL rv_missing_b: no rvalid at cycle %0d, want owner %0d data %h", q_b[0].cyc, q_b[0].own, q_b[0].data);
         void'(q_b.pop_front());
      end
      if (p_rvalid_b || s_rvalid_b) begin
         n_vec++;
         got = p_rvalid_b ? p_rdata_b : s_rdata_b;
         if (p_rvalid_b && s_rvalid_b) begin
            n_err++; $display("FAIL rv_both_b: both rvalid high at cycle %0d", cyc);
         end else if (q_b.size() == 0 || q_b[0].cyc != cyc) begin
            n_err++; $display("FAIL rv_unexpected_b: rvalid p=%b s=%b at cycle %0d, want none", p_rvalid_b, s_rvalid_b, cyc);
         end else begin
            e = q_b.pop_front();
            if (s_rvalid_b !== e.own || got !== e.data) begin
               n_err++;
               $display("FAIL rv_data_b: cycle %0d got owner %0d data %h, want owner %0d data %h", cyc, s_rvalid_b, got, e.own, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      p_req_a = 1; s_req_a = 1; p_req_b = 1; s_req_b = 1;
      tick(); tick();
      @(negedge clock);
      n_vec++; if (p_gnt_a !== 1'b0) begin n_err++; $display("FAIL rst_p_gnt: got %b want 0", p_gnt_a); end
      n_vec++; if (s_gnt_a !== 1'b0) begin n_err++; $display("FAIL rst_s_gnt: got %b want 0", s_gnt_a); end
      n_vec++; if (p_stall_a !== 1'b1) begin n_err++; $display("FAIL rst_p_stall: got %b want 1", p_stall_a); end
      n_vec++; if (mem_wren_a !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %b want 0", mem_wren_a); end
      n_vec++; if (mem_addr_a !== 12'h000) begin n_err++; $display("FAIL rst_addr: got %h want 000", mem_addr_a); end
      n_vec++; if (mem_data_a !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", mem_data_a); end
      n_vec++; if ({p_rvalid_a, s_rvalid_a} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {p_rvalid_a, s_rvalid_a}); end
      n_vec++; if ({p_gnt_b, s_gnt_b, p_stall_b} !== 3'b001) begin n_err++; $display("FAIL rst_fp_gnt: got %b want 001", {p_gnt_b, s_gnt_b, p_stall_b}); end
      p_req_a = 0; s_req_a = 0; p_req_b = 0; s_req_b = 0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_solo_p();
      p_req_a = 1; p_we_a = 1; p_addr_a = 12'h010; p_wdata_a = 32'hDEADBEEF;
      @(negedge clock);
      n_vec++; if ({p_gnt_a, p_stall_a} !== 2'b10) begin n_err++; $display("FAIL solo_wr_gnt: got gnt/stall %b want 10", {p_gnt_a, p_stall_a}); end
      n_vec++; if ({mem_wren_a, mem_addr_a, mem_data_a} !== {1'b1, 12'h010, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL solo_wr_bus: got wren %b addr %h data %h want 1 010 deadbeef", mem_wren_a, mem_addr_a, mem_data_a);
      end
      tick();
      p_we_a = 0;
      @(negedge clock);
      n_vec++; if ({p_gnt_a, p_stall_a, mem_wren_a} !== 3'b100) begin n_err++; $display("FAIL solo_rd_gnt: got gnt/stall/wren %b want 100", {p_gnt_a, p_stall_a, mem_wren_a}); end
      q_a.push_back('{1'b0, 32'hDEADBEEF, cyc + 1});
      tick();
      p_req_a = 0;
      tick(); tick();
   endtask

   task automatic test_rr_contention();
      bit exp_p;
      reset = 1'b1; tick(); reset = 1'b0;
      p_req_a = 1; p_we_a = 0; p_addr_a = 12'h001;
      s_req_a = 1; s_we_a = 0; s_addr_a = 12'h002;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         exp_p = (i % 2 == 0);
         n_vec++; if ({p_gnt_a, s_gnt_a, p_stall_a} !== {exp_p, !exp_p, !exp_p}) begin
            n_err++; $display("FAIL rr_gnt[%0d]: got p/s/stall %b want %b", i, {p_gnt_a, s_gnt_a, p_stall_a}, {exp_p, !exp_p, !exp_p});
         end
         n_vec++; if (mem_addr_a !== (exp_p ? 12'h001 : 12'h002)) begin
            n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", i, mem_addr_a, exp_p ? 12'h001 : 12'h002);
         end
         q_a.push_back('{!exp_p, pat(exp_p ? 12'h001 : 12'h002), cyc + 1});
         tick();
      end
      p_req_a = 0; s_req_a = 0;
      tick(); tick();
   endtask

   task automatic test_wr_rd_cross();
      s_req_a = 1; s_we_a = 1; s_addr_a = 12'h0FF; s_wdata_a = 32'h0000_1234;
      @(negedge clock);
      n_vec++; if ({s_gnt_a, mem_wren_a, mem_addr_a} !== {1'b1, 1'b1, 12'h0FF}) begin
         n_err++; $display("FAIL cross_wr: got gnt %b wren %b addr %h want 1 1 0ff", s_gnt_a, mem_wren_a, mem_addr_a);
      end
      tick();
      s_req_a = 0; s_we_a = 0;
      p_req_a = 1; p_we_a = 0; p_addr_a = 12'h0FF;
      @(negedge clock);
      n_vec++; if (p_gnt_a !== 1'b1) begin n_err++; $display("FAIL cross_rd_gnt: got %b want 1", p_gnt_a); end
      q_a.push_back('{1'b0, 32'h0000_1234, cyc + 1});
      tick();
      p_req_a = 0;
      tick(); tick();
   endtask

   task automatic test_reset_mid_read();
      p_req_a = 1; p_we_a = 0; p_addr_a = 12'h020; s_req_a = 0;
      reset = 1'b1;
      @(negedge clock);
      n_vec++; if ({p_gnt_a, p_stall_a} !== 2'b01) begin n_err++; $display("FAIL rmid_gnt: got gnt/stall %b want 01", {p_gnt_a, p_stall_a}); end
      tick();
      p_req_a = 0; reset = 1'b0;
      @(negedge clock);
      n_vec++; if ({p_rvalid_a, s_rvalid_a, p_gnt_a, s_gnt_a, mem_wren_a} !== 5'b0) begin
         n_err++; $display("FAIL rmid_ctl: got rv/gnt/wren %b want 00000", {p_rvalid_a, s_rvalid_a, p_gnt_a, s_gnt_a, mem_wren_a});
      end
      n_vec++; if ({mem_addr_a, mem_data_a} !== 44'h0) begin n_err++; $display("FAIL rmid_bus: got addr %h data %h want 0 0", mem_addr_a, mem_data_a); end
      tick();
      p_req_a = 1; p_addr_a = 12'h001; s_req_a = 1; s_we_a = 0; s_addr_a = 12'h002;
      @(negedge clock);
      n_vec++; if ({p_gnt_a, s_gnt_a} !== 2'b10) begin n_err++; $display("FAIL rmid_first: got p/s %b want 10", {p_gnt_a, s_gnt_a}); end
      q_a.push_back('{1'b0, pat(12'h001), cyc + 1});
      tick();
      p_req_a = 0;
      @(negedge clock);
      n_vec++; if (s_gnt_a !== 1'b1) begin n_err++; $display("FAIL rmid_s: got %b want 1", s_gnt_a); end
      q_a.push_back('{1'b1, pat(12'h002), cyc + 1});
      tick();
      s_req_a = 0;
      tick(); tick();
   endtask

   task automatic test_idle_hold();
      p_req_a = 1; p_we_a = 0; p_addr_a = 12'h3A5;
      @(negedge clock);
      n_vec++; if (p_gnt_a !== 1'b1) begin n_err++; $display("FAIL idle_rd_gnt: got %b want 1", p_gnt_a); end
      q_a.push_back('{1'b0, pat(12'h3A5), cyc + 1});
      tick();
      p_req_a = 0; p_addr_a = 12'h000; p_wdata_a = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_vec++; if ({mem_wren_a, mem_addr_a} !== {1'b0, 12'h3A5}) begin
            n_err++; $display("FAIL idle_hold[%0d]: got wren %b addr %h want 0 3a5", i, mem_wren_a, mem_addr_a);
         end
         tick();
      end
   endtask

   task automatic test_starve();
      bit exp_s;
      reset = 1'b1; tick(); reset = 1'b0;
      p_req_b = 1; p_we_b = 0; p_addr_b = 12'h004;
      s_req_b = 1; s_we_b = 0; s_addr_b = 12'h005;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         exp_s = (i == 4 || i == 9);
         n_vec++; if ({p_gnt_b, s_gnt_b, p_stall_b} !== {!exp_s, exp_s, exp_s}) begin
            n_err++; $display("FAIL starve[%0d]: got p/s/stall %b want %b", i, {p_gnt_b, s_gnt_b, p_stall_b}, {!exp_s, exp_s, exp_s});
         end
         q_b.push_back('{exp_s, pat(exp_s ? 12'h005 : 12'h004), cyc + 1});
         tick();
      end
      p_req_b = 0;
      @(negedge clock);
      n_vec++; if ({p_gnt_b, s_gnt_b} !== 2'b01) begin n_err++; $display("FAIL fp_s_alone: got p/s %b want 01", {p_gnt_b, s_gnt_b}); end
      q_b.push_back('{1'b1, pat(12'h005), cyc + 1});
      tick();
      s_req_b = 0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_solo_p();
      test_rr_contention();
      test_wr_rd_cross();
      test_reset_mid_read();
      test_idle_hold();
      test_starve();
      tick(); tick();
      n_vec++;
      if (q_a.size() + q_b.size() != 0) begin
         n_err++; $display("FAIL drain: got %0d outstanding reads want 0", q_a.size() + q_b.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters: the processor (port P) and a secondary master (port S: debug loader or memory-mapped I/O engine).
- Sits between the processor's dmem outputs and the dmem instance at top level.
- Grants one access per cycle, routes read data back to the issuing requester, and gives the processor a stall when it loses arbitration.

Parameters:
- ADDR_W, 12, dmem word-address width.
- DATA_W, 32, data width.
- P_PRIORITY, 0, 0 = round-robin between P and S; 1 = P always wins and S is served only when P is idle.
- STARVE_MAX, 4, under P_PRIORITY=1: consecutive S-blocked cycles after which S is forced through for one cycle; 0 disables forcing.

Ports:
- clock  in  1  single clock; dmem samples on the same rising edge.
- reset  in  1  synchronous, active-high.
- p_req  in  1  processor access request.
- p_we  in  1  processor write enable.
- p_addr  in  ADDR_W  processor address.
- p_wdata  in  DATA_W  processor write data.
- p_gnt  out  1  processor access accepted this cycle.
- p_stall  out  1  equals p_req & ~p_gnt.
- p_rvalid  out  1  read data for P is valid.
- p_rdata  out  DATA_W  read data for P.
- s_req, s_we, s_addr, s_wdata  in  1/1/ADDR_W/DATA_W  secondary request; fields have the same meaning as P.
- s_gnt, s_rvalid  out  1  secondary grant and read-valid.
- s_rdata  out  DATA_W  read data for S.
- mem_addr  out  ADDR_W  to dmem address.
- mem_data  out  DATA_W  to dmem data.
- mem_wren  out  1  to dmem wren.
- mem_q  in  DATA_W  from dmem q; valid one cycle after the address is presented.

Behaviour:
- Grant is combinational from the current-cycle requests and registered state.
  - At most one of p_gnt and s_gnt is high.
  - A grant implies the corresponding request is high.
- Requesters hold req, we, addr and wdata stable until they see gnt. The arbiter does not latch the request fields.
- Mux:
  - mem_addr, mem_data and mem_wren come from the granted port.
  - With no grant: mem_wren=0, and mem_addr and mem_data hold their last driven values (registered hold) to avoid spurious reads.
- Round-robin (P_PRIORITY=0):
  - A 1-bit last_owner register. On contention the port that is not last_owner wins.
  - Updated on every grant.
  - Reset value: last_owner=S, so P wins the first contention.
- Fixed priority (P_PRIORITY=1):
  - P wins on contention.
  - starve_cnt increments on each cycle where s_req & p_gnt, and clears on s_gnt or when s_req=0.
  - When starve_cnt==STARVE_MAX and STARVE_MAX≠0, S wins that cycle regardless of p_req. starve_cnt then clears.
  - starve_cnt saturates at STARVE_MAX (width clog2(STARVE_MAX+1)).
- Read return:
  - A granted read (we=0) sets a registered pending flag with an owner tag.
  - Next cycle: x_rvalid=1 for the tagged owner and x_rdata=mem_q. Latency is exactly 1 cycle after gnt.
  - Back-to-back reads, including alternating owners, are fully pipelined at one grant per cycle. No bubble is inserted.
- Writes:
  - Complete at the granted edge and produce no rvalid.
  - A read granted in the cycle after a write to the same address returns the new data (dmem write-then-read ordering).
- rdata for a non-owner, or when rvalid=0, is don't-care. The bench checks rdata only when rvalid is high.
- Reset (synchronous, evaluated at the clock edge):
  - Outputs: all gnt/rvalid=0, mem_wren=0, mem_addr=0, mem_data=0, p_stall=p_req & ~p_gnt (combinational).
  - Internal state: pending=0, last_owner=S, starve_cnt=0.
- Reset mid-operation: a read granted in the cycle reset is asserted produces no rvalid afterwards. The pending read is dropped.
- While reset is high, no grants are issued (gnt=0 and p_stall=p_req).

Decomposition:
- Shared package: owner encoding (OWNER_P=0, OWNER_S=1) and default ADDR_W/DATA_W constants, reused by the processor and the top-level wrapper.
- One natural sub-module, arb2_pick: the 2-way grant decision (round-robin or priority with starvation counter). The dmem_arbiter top level holds the mux, pending/tag pipeline and hold registers.

Test Plan:
- Solo P traffic: P writes 0xDEADBEEF to address 0x010, then reads 0x010 → p_gnt on both cycles, p_stall=0 throughout, p_rvalid one cycle after the read grant with p_rdata=0xDEADBEEF, s_rvalid never asserted.
- Contention, round-robin: p_req and s_req held high for 4 cycles, both reading 0x001/0x002 → grants in order P,S,P,S, p_stall high on cycles 2 and 4, rvalid alternates P,S,P,S one cycle later with the correct data.
- Fixed priority starvation: P_PRIORITY=1, STARVE_MAX=4, P requests every cycle, S requests from cycle 0 → S granted on cycle 4 exactly, p_stall=1 on that cycle only, P granted on all other cycles.
- Write-then-read across owners: S writes 0x0000_1234 to 0x0FF, P reads 0x0FF on the next cycle → p_rdata=0x00001234.
- Reset mid-read: P read of 0x020 granted in the same cycle reset is asserted → no p_rvalid in the following cycle, all outputs at reset values, and the first contention after reset goes to P.
- Idle hold: no requests for 3 cycles after a P read of 0x3A5 → mem_wren=0 and mem_addr stays 0x3A5, with no rvalid.
